rv_muldiv_unit: RTL

Iterative RV32M multiply/divide unit for the RISC-V CPU datapath. It sits directly upstream of the writeback result multiplexer: it accepts two operands and an M-extension funct3 code, computes over multiple cycles, and presents a registered XLEN-bit result as one input of that mux. The unit stalls the core through `busy_out` while it works.

---
 rtl/rv_muldiv_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: iterative RV32M multiply/divide unit feeding the writeback mux.
// Multiplies use radix-2 shift-add and divides use restoring division, one bit
// per cycle. Both share one accumulator/shift register pair.
//
// state  | meaning
// IDLE   | waiting for start_in; decodes special divide cases
// CALC   | XLEN iterations of shift-add or restoring division
// FIX    | sign correction and result selection into result_out
// DONE   | one-cycle done_out pulse

module rv_muldiv_unit #(
  parameter int XLEN = 32,
  parameter int CW   = $clog2(XLEN)
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            start_in,
  input  logic            kill_in,
  input  logic [2:0]      op_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  output logic            busy_out,
  output logic            done_out,
  output logic [XLEN-1:0] result_out
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_acc;      // product high half / partial remainder
  logic [XLEN-1:0] r_lo;       // product low half / dividend-quotient shifter
  logic [XLEN-1:0] r_b;        // multiplicand or divisor magnitude
  logic            r_neg_res;  // product or quotient must be negated
  logic            r_neg_rem;  // remainder must be negated (dividend sign)
  logic [XLEN-1:0] r_result;

  logic            w_accept, w_last;
  logic            w_sgn1, w_sgn2, w_neg1, w_neg2;
  logic [XLEN-1:0] w_mag1, w_mag2;
  logic            w_div0, w_ovf, w_special;
  logic [XLEN-1:0] w_special_res;
  logic [XLEN:0]   w_sum, w_rem_sh, w_diff;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0] w_quo_fix, w_rem_fix, w_fix_res;

  assign w_accept = (r_state == S_IDLE) && start_in && !kill_in;
  assign w_last   = (r_cnt == CW'(XLEN - 1));

  // Operand decode at issue: signedness, magnitudes and the special divide cases
  always_comb begin
    w_sgn1 = (op_in == 3'b001) || (op_in == 3'b010) || (op_in == 3'b100) || (op_in == 3'b110);
    w_sgn2 = (op_in == 3'b001) || (op_in == 3'b100) || (op_in == 3'b110);
    w_neg1 = w_sgn1 && rs1_in[XLEN-1];
    w_neg2 = w_sgn2 && rs2_in[XLEN-1];
    w_mag1 = w_neg1 ? -rs1_in : rs1_in;
    w_mag2 = w_neg2 ? -rs2_in : rs2_in;
    w_div0 = op_in[2] && (rs2_in == '0);
    w_ovf  = op_in[2] && !op_in[0] && (rs1_in == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_in == '1);
    w_special = w_div0 || w_ovf;
    w_special_res = '0;
    if (w_div0)
      w_special_res = op_in[1] ? rs1_in : '1;
    else
      w_special_res = op_in[1] ? '0 : rs1_in;
  end

  // One iteration step for both multiply and divide, plus the FIX-phase result
  always_comb begin
    w_sum    = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_rem_sh = {r_acc, r_lo[XLEN-1]};
    w_diff   = w_rem_sh - {1'b0, r_b};
    w_prod_fix = r_neg_res ? -{r_acc, r_lo} : {r_acc, r_lo};
    w_quo_fix  = r_neg_res ? -r_lo : r_lo;
    w_rem_fix  = r_neg_rem ? -r_acc : r_acc;
    w_fix_res  = '0;
    case (r_op)
      3'b000:                 w_fix_res = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_res = w_quo_fix;
      default:                w_fix_res = w_rem_fix;
    endcase
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  // Next-state logic; kill returns to IDLE from anywhere and drops a start in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start_in) w_next = w_special ? S_DONE : S_CALC;
      S_CALC: if (w_last)   w_next = S_FIX;
      S_FIX:                w_next = S_DONE;
      S_DONE:               w_next = S_IDLE;
      default:              w_next = S_IDLE;
    endcase
    if (kill_in) w_next = S_IDLE;
  end

  // Datapath: latch at issue, iterate in CALC, register the result in FIX
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_cnt     <= '0;
      r_op      <= '0;
      r_acc     <= '0;
      r_lo      <= '0;
      r_b       <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op      <= op_in;
          r_acc     <= '0;
          r_lo      <= w_mag1;
          r_b       <= w_mag2;
          r_cnt     <= '0;
          r_neg_res <= w_neg1 ^ w_neg2;
          r_neg_rem <= w_neg1;
          if (w_special) r_result <= w_special_res;
        end
        S_CALC: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_op[2]) begin
            r_acc <= w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
            r_lo  <= {r_lo[XLEN-2:0], ~w_diff[XLEN]};
          end else begin
            r_acc <= w_sum[XLEN:1];
            r_lo  <= {w_sum[0], r_lo[XLEN-1:1]};
          end
        end
        S_FIX: if (!kill_in) r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

  assign busy_out   = (r_state == S_CALC) || (r_state == S_FIX);
  assign done_out   = (r_state == S_DONE);
  assign result_out = r_result;

endmodule
